// File: rtl/led_uart_pkg.sv
// Shared types and helpers for the LED value UART trace: FSM encoding, ASCII constants,
// and the mapping from a captured value plus byte index to the byte on the wire.
package led_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [1:0] LAST_BYTE = 2'd3;
    localparam logic [2:0] LAST_BIT  = 3'd7;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        logic [7:0] ch;
        if (nibble < 4'd10) begin
            ch = 8'h30 + {4'h0, nibble};
        end else begin
            ch = 8'h37 + {4'h0, nibble};
        end
        return ch;
    endfunction

    // Frame layout: high nibble, low nibble, CR, LF.
    function automatic logic [7:0] frame_byte(input logic [7:0] val, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = hex_ascii(val[7:4]);
            2'd1:    b = hex_ascii(val[3:0]);
            2'd2:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, DIV cycles per bit; tx is registered, so a byte accepted
// on an edge drives its start bit from that edge. Accepts a new byte while idle or on the last stop cycle.
module uart_tx_byte
    import led_uart_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int unsigned   CW        = $clog2(DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          baud_tick;

    always_comb begin
        baud_tick  = (baud_cnt_q == BAUD_LAST);
        ready      = (state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_tick);
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;

        if (start && ready) begin
            state_d    = ST_START;
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            shreg_d    = data;
            tx_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_cnt_d = '0;
                    tx_d       = 1'b1;
                end
                ST_START: begin
                    if (baud_tick) begin
                        state_d    = ST_DATA;
                        baud_cnt_d = '0;
                        bit_idx_d  = '0;
                        tx_d       = shreg_q[0];
                    end else begin
                        baud_cnt_d = baud_cnt_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        baud_cnt_d = '0;
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end else begin
                            // Shift so the bit being driven is always shreg_q[0].
                            bit_idx_d = bit_idx_q + 3'd1;
                            shreg_d   = {1'b0, shreg_q[7:1]};
                            tx_d      = shreg_q[1];
                        end
                    end else begin
                        baud_cnt_d = baud_cnt_q + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        state_d    = ST_IDLE;
                        baud_cnt_d = '0;
                        tx_d       = 1'b1;
                    end else begin
                        baud_cnt_d = baud_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/led_value_uart_tx.sv
// Sends each new LED counter value as "HH\r\n" over UART; frame starts two edges after a change.
// Never stalls upstream: overrun keeps only the newest value.
module led_value_uart_tx
    import led_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;

    logic [7:0] prev_q, prev_d;
    logic [7:0] snap_q, snap_d;
    logic       pending_q, pending_d;
    logic [7:0] frame_val_q, frame_val_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic       busy_q, busy_d;

    logic       changed;
    logic       launch;
    logic       advance;
    logic       finish;
    logic       ser_start;
    logic       ser_ready;
    logic [7:0] ser_data;
    logic [7:0] sel_val;
    logic [1:0] sel_idx;

    always_comb begin
        changed = (value != prev_q);
        launch  = !busy_q && pending_q;
        advance = busy_q && ser_ready && (byte_idx_q != LAST_BYTE);
        finish  = busy_q && ser_ready && (byte_idx_q == LAST_BYTE);

        // A launch reads the old snap even if a change lands on the same edge.
        sel_val   = launch ? snap_q : frame_val_q;
        sel_idx   = launch ? 2'd0 : (byte_idx_q + 2'd1);
        ser_start = launch || advance;
        ser_data  = frame_byte(sel_val, sel_idx);

        prev_d      = value;
        snap_d      = changed ? value : snap_q;
        pending_d   = changed ? 1'b1 : (launch ? 1'b0 : pending_q);
        frame_val_d = launch ? snap_q : frame_val_q;

        byte_idx_d = byte_idx_q;
        if (launch) begin
            byte_idx_d = 2'd0;
        end else if (advance) begin
            byte_idx_d = byte_idx_q + 2'd1;
        end

        busy_d = busy_q;
        if (launch) begin
            busy_d = 1'b1;
        end else if (finish) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= 8'h00;
            snap_q      <= 8'h00;
            pending_q   <= 1'b0;
            frame_val_q <= 8'h00;
            byte_idx_q  <= 2'd0;
            busy_q      <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            snap_q      <= snap_d;
            pending_q   <= pending_d;
            frame_val_q <= frame_val_d;
            byte_idx_q  <= byte_idx_d;
            busy_q      <= busy_d;
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_ser (
        .clk   (clk),
        .rst   (rst),
        .start (ser_start),
        .data  (ser_data),
        .tx    (tx),
        .ready (ser_ready)
    );

    assign busy = busy_q;

endmodule

// File: doc/led_value_uart_tx.md
# led_value_uart_tx

Downstream consumer of the 8-bit LED counter value. Watches the value every clock. On each change it transmits the new value over a UART TX line as two uppercase ASCII hex digits followed by CR LF. The link is 8N1, LSB first. It sits beside the LED outputs on the same clock and gives a host-visible trace of the count.

## Interface
- `CLK_FREQ`, default 25_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate. Bit period `DIV = CLK_FREQ / BAUD` (integer division, must be ≥ 2).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `value` input 8: counter value, synchronous to `clk`, may change on any cycle.
- `tx` output 1: UART serial out, idle high.
- `busy` output 1: high while a frame is being transmitted.

## Operation
- **Change detect.**
  - `prev` (8 bit) is loaded with `value` every cycle.
  - `value != prev` at an edge sets `pending` and loads `snap <= value`.
  - Later changes overwrite `snap`: only the newest value is kept, and intermediate values are dropped.
- **Frame.** Four bytes in order: `hex(snap[7:4])`, `hex(snap[3:0])`, 0x0D, 0x0A.
  - Nibbles 0–9 map to 0x30–0x39.
  - Nibbles A–F map to 0x41–0x46.
- **Byte format.** Start bit 0, then data bits d0..d7, then stop bit 1. Each bit lasts exactly `DIV` cycles.
- **FSM states.**
  - IDLE: `tx=1`, `busy=0`. If `pending` is set, latch `frame_val <= snap`, clear `pending`, reset the byte index to 0, and go to START.
  - START: `tx=0` for `DIV` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = current bit. Advance every `DIV` cycles. After bit 7, go to STOP.
  - STOP: `tx=1` for `DIV` cycles. If the byte index is below 3, increment it and go to START. Otherwise go to IDLE.
- **Simultaneous change and frame launch.** If a change is detected on the same edge that IDLE launches a frame:
  - the launching frame uses the old `snap`;
  - `pending` stays set;
  - `snap` takes the new value;
  - a second frame follows.
- **Arithmetic.**
  - The baud counter is `$clog2(DIV)` bits wide and wraps at `DIV-1`.
  - The bit index is 3 bits; the byte index is 2 bits.
  - No counter is ever allowed to run past its terminal value.

## Timing
- **Reset values** (reset applied at any edge, including mid-frame):
  - `tx=1` and `busy=0` from the cycle after the reset edge;
  - `prev=0x00`, `snap=0x00`, `pending=0`;
  - FSM in IDLE, all counters 0.
- **After reset release.** `value` staying at 0x00 produces no frame.
- **Latency.**
  - `value` changes before edge N, so `pending` is set at edge N.
  - IDLE launches at edge N+1, so `tx` falls and `busy` rises from edge N+1.
- **Frame length.** 4 × 10 × `DIV` cycles. `busy` falls at the same edge `tx` ends the last stop bit.
- **Back-to-back frames.** Exactly one IDLE cycle (`tx=1`, `busy=0`) separates the final stop bit from the next start bit.
- **No handshake.** Upstream is never stalled. Overrun is handled only by keeping the newest value.

## Structure
- Shared package `led_uart_pkg` holds:
  - the FSM state encoding (IDLE, START, DATA, STOP);
  - ASCII constants `ASCII_CR=8'h0D`, `ASCII_LF=8'h0A`;
  - a `hex_ascii(nibble)` function.
- One sub-module, `uart_tx_byte`, the byte serializer.
  - Ports: `clk`, `rst`, `start`, `data[7:0]`, `tx`, `ready`.
  - It owns the baud counter, the bit index, and the START/DATA/STOP sequencing.
- The top level owns change detect, `snap`/`pending`, the byte index, and byte selection.

## Test plan
All scenarios use `CLK_FREQ=16`, `BAUD=1` (`DIV=16`).
1. **Reset quiet.** Hold `rst` 3 cycles, release, keep `value=0x00` for 1000 cycles → `tx` constantly 1, `busy` constantly 0.
2. **Single frame.** `value` goes 0x00 → 0x3A → `tx` falls 2 edges later. UART decode yields 0x33, 0x41, 0x0D, 0x0A, and `busy` is high for exactly 640 cycles.
3. **Overrun.** Change to 0x01, then during the frame change to 0x02 and then 0x7F → frame "01\r\n", one idle cycle, then exactly one further frame "7F\r\n". No "02" is ever sent.
4. **Simultaneous change.** A change to 0x05 lands on the launch edge of pending 0x04 → frame "04\r\n" followed by frame "05\r\n".
5. **Reset mid-frame.** Assert `rst` during the DATA bit 3 of byte 1 → `tx=1` and `busy=0` on the next cycle. After release, no frame until `value` differs from 0x00.
6. **Hex coverage.** Step `value` through 0x09, 0x0A, 0xF0, 0xFF, each held longer than 640 cycles → frames "09", "0A", "F0", "FF", each terminated by CR LF, with uppercase letters.
